// File: rtl/hazard_stall_unit.sv
// Load-use / beq hazard controller beside the ID stage.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
  parameter int BR_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_valid,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ctrl_zero,
  output logic        ifid_flush,
  output logic        hazard_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int CW = $clog2(BR_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(BR_TIMEOUT - 1);

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic          err_set;

  logic uses_rt, load_use, is_beq;
  logic bw, run_path;
  logic c_rst, c_take, c_wait, c_lu, c_beq;

  assign is_beq  = id_opcode == 6'd4;
  assign uses_rt = (id_opcode == 6'd0) | is_beq
                 | (id_opcode == 6'd43);
  assign load_use = ex_mem_read & (ex_rt != 5'd0)
                  & ((ex_rt == id_rs)
                  | (uses_rt & (ex_rt == id_rt)));

  // A not-taken resolution behaves exactly like RUN.
  assign bw       = state == BR_WAIT;
  assign run_path = !bw | (branch_valid & !branch_taken);

  assign c_rst  = !rst_n;
  assign c_take = rst_n & bw & branch_valid & branch_taken;
  assign c_wait = rst_n & bw & !branch_valid;
  assign c_lu   = rst_n & run_path & load_use;
  assign c_beq  = rst_n & run_path & !load_use & is_beq;

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ctrl_zero  = 1'b0;
    ifid_flush = 1'b0;
    state_nxt  = RUN;
    wait_nxt   = wait_cnt;
    err_set    = 1'b0;
    unique case (1'b1)
      c_rst: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ctrl_zero  = 1'b1;
      end
      c_take: begin
        ctrl_zero  = 1'b1;
        ifid_flush = 1'b1;
      end
      c_wait: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ctrl_zero  = 1'b1;
        wait_nxt   = wait_cnt + CW'(1);
        if (wait_cnt == LAST) begin
          err_set = 1'b1;
        end else begin
          state_nxt = BR_WAIT;
        end
      end
      c_lu: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ctrl_zero  = 1'b1;
      end
      c_beq: begin
        state_nxt = BR_WAIT;
        wait_nxt  = '0;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      wait_cnt   <= '0;
      hazard_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) hazard_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write)  stall_q <= stall_q + 32'd1;
      if (ifid_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with an expectation queue.
// Counter checks follow HAZARD_PERF_CNT_EN.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  id_opcode = '0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rt = '0;
  logic        branch_valid = 1'b0;
  logic        branch_taken = 1'b0;
  logic        pc_write, ifid_write, ctrl_zero, ifid_flush;
  logic        hazard_err;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] val;
    logic [4:0] mask;
    string      tag;
  } exp_t;

  exp_t sb[$];

  // {pc_write, ifid_write, ctrl_zero, ifid_flush, hazard_err}
  localparam logic [4:0] GO   = 5'b11000;
  localparam logic [4:0] STL  = 5'b00100;
  localparam logic [4:0] GOE  = 5'b11001;
  localparam logic [4:0] STLE = 5'b00101;
  localparam logic [4:0] TAKE = 5'b10110;
  localparam logic [4:0] ALL  = 5'b11111;
  localparam logic [4:0] NOIW = 5'b10111;

  hazard_stall_unit #(.BR_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_valid(branch_valid), .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ctrl_zero(ctrl_zero), .ifid_flush(ifid_flush),
    .hazard_err(hazard_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(
    input logic       rn,
    input logic [5:0] op,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       mr,
    input logic [4:0] ert,
    input logic       bv,
    input logic       bt,
    input logic [4:0] e,
    input logic [4:0] m,
    input string      tag
  );
    exp_t x;
    logic [4:0] obs;
    @(negedge clk);
    rst_n = rn;
    id_opcode = op;
    id_rs = rs;
    id_rt = rt;
    ex_mem_read = mr;
    ex_rt = ert;
    branch_valid = bv;
    branch_taken = bt;
    sb.push_back('{val: e, mask: m, tag: tag});
    #1;
    x = sb.pop_front();
    obs = {pc_write, ifid_write, ctrl_zero, ifid_flush, hazard_err};
    checks++;
    assert ((obs & x.mask) === (x.val & x.mask)) else begin
      errors++;
      $error("FAIL %s: got %b expected %b (mask %b)",
             x.tag, obs, x.val, x.mask);
    end
  endtask

  task automatic chk_cnt(
    input string tag, input logic [31:0] es, input logic [31:0] ef
  );
    checks++;
    assert (stall_cnt === es && flush_cnt === ef) else begin
      errors++;
      $error("FAIL %s: stall %0d flush %0d expected %0d %0d",
             tag, stall_cnt, flush_cnt, es, ef);
    end
  endtask

  initial begin
    logic [31:0] es3, ef3;
`ifdef HAZARD_PERF_CNT_EN
    es3 = 32'd2;
    ef3 = 32'd1;
`else
    es3 = 32'd0;
    ef3 = 32'd0;
`endif
    // reset
    step(0, 0, 0, 0, 0, 0, 0, 0, STL, ALL, "reset_out");
    chk_cnt("reset_cnt", 0, 0);
    // load-use on rs, then clears
    step(1, 0, 2, 3, 1, 2, 0, 0, STL, ALL, "lu_rs");
    step(1, 0, 2, 3, 0, 2, 0, 0, GO, ALL, "lu_clear");
    // ex_rt==0, lw rt, sw rt
    step(1, 0, 0, 0, 1, 0, 0, 0, GO, ALL, "lu_r0");
    step(1, 35, 1, 5, 1, 5, 0, 0, GO, ALL, "lw_rt");
    step(1, 43, 1, 5, 1, 5, 0, 0, STL, ALL, "sw_rt");
    // beq with load-use stalls and stays in RUN
    step(1, 4, 1, 5, 1, 5, 0, 0, STL, ALL, "beq_lu");
    step(1, 0, 1, 2, 0, 0, 0, 0, GO, ALL, "beq_lu_run");
    // branch_valid in RUN ignored
    step(1, 0, 1, 2, 0, 0, 1, 1, GO, ALL, "bv_in_run");
    // taken beq from fresh reset, counters
    step(0, 0, 0, 0, 0, 0, 0, 0, STL, ALL, "reset2");
    step(1, 4, 1, 2, 0, 0, 0, 0, GO, ALL, "t3_issue");
    step(1, 4, 1, 2, 0, 0, 0, 0, STL, ALL, "t3_wait1");
    step(1, 4, 1, 2, 0, 0, 0, 0, STL, ALL, "t3_wait2");
    step(1, 4, 1, 2, 1, 1, 1, 1, TAKE, NOIW, "t3_taken");
    step(1, 0, 1, 2, 0, 0, 0, 0, GO, ALL, "t3_run");
    chk_cnt("t3_cnt", es3, ef3);
    // not-taken with beq in ID re-enters BR_WAIT
    step(1, 4, 1, 2, 0, 0, 0, 0, GO, ALL, "t4_issue");
    step(1, 4, 1, 2, 0, 0, 0, 0, STL, ALL, "t4_wait");
    step(1, 4, 1, 2, 0, 0, 1, 0, GO, ALL, "t4_nt_beq");
    step(1, 4, 1, 2, 0, 0, 0, 0, STL, ALL, "t4_rewait");
    step(1, 0, 1, 2, 0, 0, 1, 0, GO, ALL, "t4_nt");
    step(1, 0, 1, 2, 0, 0, 0, 0, GO, ALL, "t4_run");
    // watchdog: 8 wait cycles then RUN with sticky error
    step(1, 4, 1, 2, 0, 0, 0, 0, GO, ALL, "t5_issue");
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 2, 0, 0, 0, 0, STL, ALL, $sformatf("t5_wait%0d", i));
    end
    step(1, 0, 1, 2, 0, 0, 0, 0, GOE, ALL, "t5_err");
    step(1, 0, 1, 2, 0, 0, 1, 1, GOE, ALL, "t5_sticky");
    // reset mid BR_WAIT
    step(1, 4, 1, 2, 0, 0, 0, 0, GOE, ALL, "t6_issue");
    step(1, 4, 1, 2, 0, 0, 0, 0, STLE, ALL, "t6_wait");
    step(0, 4, 1, 2, 0, 0, 0, 0, STL, ALL, "t6_reset");
    chk_cnt("t6_cnt", 0, 0);
    step(1, 0, 1, 2, 0, 0, 0, 0, GO, ALL, "t6_release");
    step(1, 0, 1, 2, 0, 0, 0, 0, GO, ALL, "t6_run");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
